// File: rtl/reaction_pkg.sv
// reaction_pkg
//   Shared definitions for the reaction-delay timer slice: FSM state encoding,
//   default timing constants and the widths of the random and delay values.
//   Holds no ports; imported by the interface, the top and its testbench.
package reaction_pkg;

  // Default timing for a 50 MHz clock.
  localparam int DEFAULT_TICKS_PER_MS = 50000;
  localparam int DEFAULT_MIN_DELAY_MS = 1000;
  localparam int DEFAULT_RT_MAX_MS    = 9999;

  // random_num is the 12-bit LFSR value; floor + random fits in 13 bits.
  localparam int RANDOM_W = 12;
  localparam int DELAY_W  = 13;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_DELAY = 2'd1;
  localparam logic [1:0] ST_ARMED = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    DELAY = ST_DELAY,
    ARMED = ST_ARMED,
    DONE  = ST_DONE
  } state_t;

endpackage

// File: rtl/reaction_delay_timer_if.sv
// reaction_delay_timer_if
//   Groups the request/response signals of the reaction-delay timer.
//   master: drives random_num, start, react; receives the LED, busy and result.
//   slave : the timer itself.
//   Signals: random_num[12], start, react, led_on, busy, result_valid,
//            reaction_ms[RT_W], false_start, timeout.
interface reaction_delay_timer_if import reaction_pkg::*; #(
  parameter int RT_W = 14
);
  logic [RANDOM_W-1:0] random_num;
  logic                start;
  logic                react;
  logic                led_on;
  logic                busy;
  logic                result_valid;
  logic [RT_W-1:0]     reaction_ms;
  logic                false_start;
  logic                timeout;

  modport master (
    output random_num, start, react,
    input  led_on, busy, result_valid, reaction_ms, false_start, timeout
  );

  modport slave (
    input  random_num, start, react,
    output led_on, busy, result_valid, reaction_ms, false_start, timeout
  );
endinterface

// File: rtl/ms_tick_prescaler.sv
// ms_tick_prescaler
//   Divides clk50M down to a one-cycle millisecond tick.
//   Ports: clk50M (clock), reset_n (async active-low reset),
//          clear (restart the millisecond from zero), tick (high on the wrap cycle).
module ms_tick_prescaler #(
  parameter int TICKS_PER_MS = 50000
) (
  input  logic clk50M,
  input  logic reset_n,
  input  logic clear,
  output logic tick
);
  localparam int CW = (TICKS_PER_MS > 2) ? $clog2(TICKS_PER_MS) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICKS_PER_MS - 1);

  logic [CW-1:0] count;

  assign tick = (count == LAST);

  // clear wins over the wrap so a fresh phase always starts with a full millisecond.
  always_ff @(posedge clk50M or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clear || tick) begin
      count <= '0;
    end else begin
      count <= count + CW'(1);
    end
  end
endmodule

// File: rtl/reaction_delay_timer.sv
// reaction_delay_timer
//   Waits a random delay after a start request, lights the stimulus LED and
//   measures the reaction time in whole milliseconds, flagging false starts
//   and timeouts.
//   Ports: clk50M (clock), reset_n (async active-low reset),
//          bus (slave side of reaction_delay_timer_if: random_num, start, react in;
//               led_on, busy, result_valid, reaction_ms, false_start, timeout out).
module reaction_delay_timer import reaction_pkg::*; #(
  parameter int TICKS_PER_MS = DEFAULT_TICKS_PER_MS,
  parameter int MIN_DELAY_MS = DEFAULT_MIN_DELAY_MS,
  parameter int RT_MAX_MS    = DEFAULT_RT_MAX_MS,
  parameter int RT_W         = 14
) (
  input  logic                   clk50M,
  input  logic                   reset_n,
  reaction_delay_timer_if.slave  bus
);
  localparam int CNT_W = (RT_W > DELAY_W) ? RT_W : DELAY_W;

  state_t             state, state_nx;
  logic [CNT_W-1:0]   ms_cnt;
  logic [CNT_W-1:0]   ms_next;
  logic [DELAY_W-1:0] delay_ms;
  logic               react_prev;
  logic               react_edge;
  logic               tick;
  logic               prescale_clear;
  logic               delay_done;
  logic               rt_limit;
  logic               false_hit;
  logic               press_hit;
  logic               timeout_hit;

  logic               led_on_r;
  logic               busy_r;
  logic               result_valid_r;
  logic [RT_W-1:0]    reaction_ms_r;
  logic               false_start_r;
  logic               timeout_r;

  ms_tick_prescaler #(
    .TICKS_PER_MS (TICKS_PER_MS)
  ) u_prescaler (
    .clk50M  (clk50M),
    .reset_n (reset_n),
    .clear   (prescale_clear),
    .tick    (tick)
  );

  // "Reaching" a count means the tick that would move the counter onto it,
  // so the phase change lands on exactly count*TICKS_PER_MS cycles.
  assign ms_next    = ms_cnt + CNT_W'(1);
  assign delay_done = tick && (ms_next == CNT_W'(delay_ms));
  assign rt_limit   = tick && (ms_next == CNT_W'(RT_MAX_MS));
  assign react_edge = bus.react && !react_prev;

  // A held button counts as a false start at the edge that would light the LED.
  always_comb begin
    state_nx       = state;
    prescale_clear = 1'b0;
    false_hit      = 1'b0;
    press_hit      = 1'b0;
    timeout_hit    = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          state_nx       = DELAY;
          prescale_clear = 1'b1;
        end
      end
      DELAY: begin
        if (react_edge || (bus.react && delay_done)) begin
          false_hit = 1'b1;
          state_nx  = DONE;
        end else if (delay_done) begin
          state_nx       = ARMED;
          prescale_clear = 1'b1;
        end
      end
      ARMED: begin
        if (react_edge) begin
          press_hit = 1'b1;
          state_nx  = DONE;
        end else if (rt_limit) begin
          timeout_hit = 1'b1;
          state_nx    = DONE;
        end
      end
      DONE: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk50M or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // The edge detector follows react in every state, so a press that coincides
  // with start is already "old" once DELAY begins.
  always_ff @(posedge clk50M or negedge reset_n) begin
    if (!reset_n) begin
      react_prev <= 1'b0;
    end else begin
      react_prev <= bus.react;
    end
  end

  always_ff @(posedge clk50M or negedge reset_n) begin
    if (!reset_n) begin
      delay_ms <= '0;
    end else if (state == IDLE && bus.start) begin
      delay_ms <= DELAY_W'(MIN_DELAY_MS) + {1'b0, bus.random_num};
    end
  end

  always_ff @(posedge clk50M or negedge reset_n) begin
    if (!reset_n) begin
      ms_cnt <= '0;
    end else if (prescale_clear) begin
      ms_cnt <= '0;
    end else if (tick && (state == DELAY || state == ARMED)) begin
      ms_cnt <= ms_next;
    end
  end

  // A press on a tick edge already owns that millisecond, hence ms_cnt + tick.
  always_ff @(posedge clk50M or negedge reset_n) begin
    if (!reset_n) begin
      led_on_r       <= 1'b0;
      busy_r         <= 1'b0;
      result_valid_r <= 1'b0;
      reaction_ms_r  <= '0;
      false_start_r  <= 1'b0;
      timeout_r      <= 1'b0;
    end else begin
      led_on_r       <= (state_nx == ARMED);
      busy_r         <= (state_nx == DELAY) || (state_nx == ARMED);
      result_valid_r <= (state_nx == DONE);
      if (false_hit) begin
        reaction_ms_r <= '0;
        false_start_r <= 1'b1;
        timeout_r     <= 1'b0;
      end else if (press_hit) begin
        reaction_ms_r <= RT_W'(ms_cnt + CNT_W'(tick));
        false_start_r <= 1'b0;
        timeout_r     <= 1'b0;
      end else if (timeout_hit) begin
        reaction_ms_r <= RT_W'(RT_MAX_MS);
        false_start_r <= 1'b0;
        timeout_r     <= 1'b1;
      end
    end
  end

  assign bus.led_on       = led_on_r;
  assign bus.busy         = busy_r;
  assign bus.result_valid = result_valid_r;
  assign bus.reaction_ms  = reaction_ms_r;
  assign bus.false_start  = false_start_r;
  assign bus.timeout      = timeout_r;
endmodule

// File: tb/tb_reaction_delay_timer.sv
// tb_reaction_delay_timer
//   Directed scenarios plus randomized start/react traffic, checked every cycle
//   against a timestamp-based model of the reaction timer.
module tb_reaction_delay_timer;
  localparam int T     = 4;
  localparam int MIN   = 2;
  localparam int RTMAX = 20;
  localparam int RT_W  = 14;
  localparam int SIG_LED = 0;
  localparam int SIG_RV  = 1;

  logic clk50M = 1'b0;
  logic reset_n;

  int n_cmp  = 0;
  int n_fail = 0;

  reaction_delay_timer_if #(.RT_W(RT_W)) rif ();

  reaction_delay_timer #(
    .TICKS_PER_MS (T),
    .MIN_DELAY_MS (MIN),
    .RT_MAX_MS    (RTMAX),
    .RT_W         (RT_W)
  ) dut (
    .clk50M  (clk50M),
    .reset_n (reset_n),
    .bus     (rif.slave)
  );

  always #5 clk50M = ~clk50M;

  // Model: every run is described by its start edge and the edge on which the
  // LED must light; all results follow from edge arithmetic on those stamps.
  int  now_edge   = 0;
  bit  m_active   = 0;
  int  m_t_start  = 0;
  int  m_t_led    = 0;
  int  m_t_result = -10;
  bit  m_prev     = 0;
  bit  m_rise;
  int  m_el;
  bit  e_led = 0, e_busy = 0, e_rv = 0, e_fs = 0, e_to = 0;
  int  e_rms = 0;

  function automatic void modelResult(input int rms, input bit fs, input bit to);
    m_active   = 0;
    e_rv       = 1;
    e_rms      = rms;
    e_fs       = fs;
    e_to       = to;
    m_t_result = now_edge;
  endfunction

  always @(posedge clk50M or negedge reset_n) begin
    if (!reset_n) begin
      m_active   = 0;
      m_prev     = 0;
      m_t_result = -10;
      e_led = 0; e_busy = 0; e_rv = 0; e_fs = 0; e_to = 0; e_rms = 0;
    end else begin
      now_edge++;
      m_rise = rif.react && !m_prev;
      m_prev = rif.react;
      e_rv   = 0;
      if (m_active) begin
        if (now_edge < m_t_led) begin
          if (m_rise) modelResult(0, 1, 0);
        end else if (now_edge == m_t_led) begin
          if (rif.react) modelResult(0, 1, 0);
        end else begin
          m_el = now_edge - m_t_led;
          if (m_rise) modelResult(m_el / T, 0, 0);
          else if (m_el == RTMAX * T) modelResult(RTMAX, 0, 1);
        end
      end else if (rif.start && now_edge != m_t_result + 1) begin
        m_active  = 1;
        m_t_start = now_edge;
        m_t_led   = now_edge + (MIN + int'(rif.random_num)) * T;
      end
      e_busy = m_active;
      e_led  = m_active && (now_edge >= m_t_led);
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Per-cycle comparison against the model.
  always @(negedge clk50M) begin
    checkOutput("led_on",       32'(rif.led_on),       32'(e_led));
    checkOutput("busy",         32'(rif.busy),         32'(e_busy));
    checkOutput("result_valid", 32'(rif.result_valid), 32'(e_rv));
    checkOutput("reaction_ms",  32'(rif.reaction_ms),  32'(e_rms));
    checkOutput("false_start",  32'(rif.false_start),  32'(e_fs));
    checkOutput("timeout",      32'(rif.timeout),      32'(e_to));
  end

  task automatic applyStimulus(input bit st, input logic [11:0] rnd, input bit rc);
    @(negedge clk50M);
    rif.start      = st;
    rif.random_num = rnd;
    rif.react      = rc;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk50M);
  endtask

  // Start pulse; returns at the falling edge right after the start edge.
  task automatic pulseStart(input logic [11:0] rnd);
    applyStimulus(1'b1, rnd, rif.react);
    applyStimulus(1'b0, ~rnd, rif.react);
  endtask

  task automatic waitSig(input string tag, input int which, input int budget, output int n);
    n = 0;
    for (int k = 1; k <= budget; k++) begin
      @(negedge clk50M);
      if ((which == SIG_LED && rif.led_on) || (which == SIG_RV && rif.result_valid)) begin
        n = k;
        break;
      end
    end
    if (n == 0) begin
      n_cmp++;
      n_fail++;
      $display("[TB] FAIL %s wait: got no event in %0d cycles, expected one", tag, budget);
    end
  endtask

  task automatic runBasic(input string tag);
    int n;
    pulseStart(12'd3);
    waitSig(tag, SIG_LED, 200, n);
    checkOutput({tag, " led latency"}, 32'(n), 32'd20);
    checkOutput({tag, " model led edge"}, 32'(m_t_led - m_t_start), 32'd20);
    idle(9);
    rif.react = 1'b1;
    @(negedge clk50M);
    checkOutput({tag, " valid"},    32'(rif.result_valid), 32'd1);
    checkOutput({tag, " reaction"}, 32'(rif.reaction_ms),  32'd2);
    checkOutput({tag, " false"},    32'(rif.false_start),  32'd0);
    checkOutput({tag, " timeout"},  32'(rif.timeout),      32'd0);
    checkOutput({tag, " led off"},  32'(rif.led_on),       32'd0);
    rif.react = 1'b0;
    idle(3);
  endtask

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: got no finish, expected end of test");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    reset_n        = 1'b1;
    rif.start      = 1'b0;
    rif.react      = 1'b0;
    rif.random_num = '0;
    #1 reset_n = 1'b0;
    @(negedge clk50M);
    checkOutput("reset led_on",   32'(rif.led_on),       32'd0);
    checkOutput("reset busy",     32'(rif.busy),         32'd0);
    checkOutput("reset valid",    32'(rif.result_valid), 32'd0);
    checkOutput("reset reaction", 32'(rif.reaction_ms),  32'd0);
    idle(2);
    reset_n = 1'b1;
    idle(2);

    // Normal reaction of 10 cycles after a 5 ms delay.
    runBasic("s1");

    // Early press, rising edge inside the delay.
    pulseStart(12'd0);
    idle(2);
    rif.react = 1'b1;
    @(negedge clk50M);
    checkOutput("s2 valid",    32'(rif.result_valid), 32'd1);
    checkOutput("s2 false",    32'(rif.false_start),  32'd1);
    checkOutput("s2 reaction", 32'(rif.reaction_ms),  32'd0);
    checkOutput("s2 led",      32'(rif.led_on),       32'd0);
    rif.react = 1'b0;
    idle(3);

    // Button held through the whole delay.
    rif.react = 1'b1;
    idle(2);
    pulseStart(12'd1);
    waitSig("s3", SIG_RV, 100, n);
    checkOutput("s3 latency", 32'(n), 32'd12);
    checkOutput("s3 false",   32'(rif.false_start), 32'd1);
    rif.react = 1'b0;
    idle(3);

    // No press at all.
    pulseStart(12'd5);
    waitSig("s4 led", SIG_LED, 200, n);
    checkOutput("s4 led latency", 32'(n), 32'd28);
    waitSig("s4 rv", SIG_RV, 200, n);
    checkOutput("s4 timeout latency", 32'(n), 32'd80);
    checkOutput("s4 timeout",  32'(rif.timeout),     32'd1);
    checkOutput("s4 reaction", 32'(rif.reaction_ms), 32'd20);
    checkOutput("s4 false",    32'(rif.false_start), 32'd0);
    idle(3);

    // Extra starts while busy, then start held across the DONE cycle.
    pulseStart(12'd3);
    idle(4);
    rif.start = 1'b1; rif.random_num = 12'd9;
    idle(1);
    rif.start = 1'b0;
    waitSig("s5 led", SIG_LED, 200, n);
    checkOutput("s5 led latency", 32'(n + 5), 32'd20);
    idle(2);
    rif.start = 1'b1;
    idle(1);
    rif.start = 1'b0;
    idle(6);
    rif.react = 1'b1;
    @(negedge clk50M);
    checkOutput("s5 valid",    32'(rif.result_valid), 32'd1);
    checkOutput("s5 reaction", 32'(rif.reaction_ms),  32'd2);
    rif.react = 1'b0;
    rif.start = 1'b1;
    rif.random_num = 12'd0;
    @(negedge clk50M);
    checkOutput("s5 start in done", 32'(rif.busy), 32'd0);
    @(negedge clk50M);
    checkOutput("s5 start after done", 32'(rif.busy), 32'd1);
    rif.start = 1'b0;
    waitSig("s5b led", SIG_LED, 100, n);
    checkOutput("s5b led latency", 32'(n), 32'd8);
    idle(4);
    rif.react = 1'b1;
    @(negedge clk50M);
    checkOutput("s5b reaction", 32'(rif.reaction_ms), 32'd1);
    rif.react = 1'b0;
    idle(3);

    // Asynchronous reset in the middle of a measurement.
    pulseStart(12'd3);
    waitSig("s6", SIG_LED, 200, n);
    idle(3);
    @(posedge clk50M);
    #2 reset_n = 1'b0;
    #1;
    checkOutput("s6 led async",   32'(rif.led_on),       32'd0);
    checkOutput("s6 busy async",  32'(rif.busy),         32'd0);
    checkOutput("s6 valid async", 32'(rif.result_valid), 32'd0);
    idle(2);
    reset_n = 1'b1;
    idle(2);
    runBasic("s6 again");

    // Random traffic: frequent presses first, then sparse ones to reach timeouts.
    for (int i = 0; i < 6000; i++) begin
      @(negedge clk50M);
      rif.start = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 199) == 0) rif.random_num = 12'($urandom);
      else rif.random_num = 12'($urandom_range(0, 6));
      if (i < 3000) begin
        if ($urandom_range(0, 7) == 0) rif.react = ~rif.react;
      end else begin
        if ($urandom_range(0, 149) == 0) rif.react = ~rif.react;
      end
    end
    rif.start = 1'b0;
    rif.react = 1'b0;
    idle(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
